// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx
//   Packet-level UART transmitter for the command link. Bytes (with a
//   last-of-packet flag) are queued in a small FIFO and sent as
//   start / DATA_W data bits LSB first / optional parity / STOP_BITS stop
//   frames. Frames within a packet are contiguous. GAP_BITS idle bit periods
//   follow each packet.
//
//   Ports
//     CLK, rst            clock, synchronous active-high reset
//     in_data/in_last     byte to queue and its end-of-packet flag
//     in_valid/in_ready   enqueue handshake (in_ready low when full or in reset)
//     PAR_EN, PAR_TYP     parity enable, 0 = even / 1 = odd
//     PRESCALE            CLK cycles per bit, clamped to a minimum of 4
//     TX_OUT              serial line, idle high
//     busy                transmitter not idle
//     frame_done          pulse in the last cycle of each frame
//     pkt_done            pulse in the last cycle of each packet
//     fifo_count          FIFO occupancy
//
//   Build option CMD_CHECKSUM_EN: append one frame carrying the XOR of all
//   data bytes of the packet; pkt_done then marks the end of that frame.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | line high, waiting for a queued byte
//   S_START  | start bit (low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when latched PAR_EN)
//   S_STOP   | stop bit(s), high
//   S_GAP    | inter-packet idle bits, FIFO not serviced
module uart_cmd_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 2,
    parameter int PRESC_W    = 6
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic [PRESC_W-1:0]            PRESCALE,
    output logic                          TX_OUT,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          pkt_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [DATA_W:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, empty, push, pop;
    logic [DATA_W-1:0]    head_data;
    logic                 head_last;

    logic [2:0]           state;
    logic [PRESC_W-1:0]   cyc_cnt, presc_q, presc_eff;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_W-1:0]    shreg;
    logic                 par_en_q, par_q, last_q, tx_q;
    logic                 bit_end, stop_end, more_bytes, pkt_end;
    logic                 start_frame;
    logic [DATA_W-1:0]    start_data;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign head_data = mem[rd_ptr][DATA_W-1:0];
    assign head_last = mem[rd_ptr][DATA_W];

    assign presc_eff = (PRESCALE < PRESC_W'(4)) ? PRESC_W'(4) : PRESCALE;
    assign bit_end   = (cyc_cnt == '0);
    assign stop_end  = (state == S_STOP) && bit_end && (bit_cnt == '0);

`ifdef CMD_CHECKSUM_EN
    logic                 csum_q;
    logic [DATA_W-1:0]    csum_acc;
    logic                 start_csum;

    // last_q is only ever set on data frames, so this fires once per packet
    assign start_csum  = stop_end && last_q;
    assign more_bytes  = !last_q && !csum_q;
    assign pkt_end     = stop_end && csum_q;
    assign start_frame = pop || start_csum;
    assign start_data  = start_csum ? csum_acc : head_data;

    always_ff @(posedge CLK) begin
        if (rst) begin
            csum_q   <= 1'b0;
            csum_acc <= '0;
        end else begin
            if (start_csum)
                csum_acc <= '0;
            else if (pop)
                csum_acc <= csum_acc ^ head_data;
            if (start_frame)
                csum_q <= start_csum;
        end
    end
`else
    assign more_bytes  = !last_q;
    assign pkt_end     = stop_end && last_q;
    assign start_frame = pop;
    assign start_data  = head_data;
`endif

    // Pop either from idle or straight out of a non-final stop bit so that
    // frames of one packet run back to back.
    assign pop = !empty && ((state == S_IDLE) || (stop_end && more_bytes));

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {in_last, in_data};
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            cyc_cnt  <= '0;
            presc_q  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            // bit timer: down-count, reload at terminal count
            cyc_cnt <= bit_end ? presc_q - 1'b1 : cyc_cnt - 1'b1;

            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_cnt <= BCW'(DATA_W - 1);
                        tx_q    <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                        end else if (par_en_q) begin
                            state <= S_PARITY;
                            tx_q  <= par_q;
                        end else begin
                            state   <= S_STOP;
                            tx_q    <= 1'b1;
                            bit_cnt <= BCW'(STOP_BITS - 1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        tx_q    <= 1'b1;
                        bit_cnt <= BCW'(STOP_BITS - 1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt != '0)
                            bit_cnt <= bit_cnt - 1'b1;
                        else if (more_bytes || GAP_BITS == 0)
                            state <= S_IDLE;
                        else begin
                            state   <= S_GAP;
                            bit_cnt <= BCW'(GAP_BITS - 1);
                        end
                    end
                end
                S_GAP: begin
                    if (bit_end) begin
                        if (bit_cnt == '0)
                            state <= S_IDLE;
                        else
                            bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // New frame: latch byte and line config; overrides the case above.
            if (start_frame) begin
                state    <= S_START;
                tx_q     <= 1'b0;
                cyc_cnt  <= presc_eff - 1'b1;
                presc_q  <= presc_eff;
                par_en_q <= PAR_EN;
                par_q    <= (^start_data) ^ PAR_TYP;
                shreg    <= start_data;
`ifdef CMD_CHECKSUM_EN
                last_q   <= head_last && !start_csum;
`else
                last_q   <= head_last;
`endif
            end
        end
    end

    assign TX_OUT     = tx_q;
    assign busy       = (state != S_IDLE);
    assign frame_done = stop_end && !rst;
    assign pkt_done   = pkt_end && !rst;
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
module tb_uart_cmd_frame_tx;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int STOP_BITS  = 1;
    localparam int GAP_BITS   = 2;
    localparam int PRESC_W    = 6;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                CLK = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   in_data;
    logic                in_last, in_valid, in_ready;
    logic                PAR_EN, PAR_TYP;
    logic [PRESC_W-1:0]  PRESCALE;
    logic                TX_OUT, busy, frame_done, pkt_done;
    logic [CW-1:0]       fifo_count;

    uart_cmd_frame_tx #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STOP_BITS(STOP_BITS),
        .GAP_BITS(GAP_BITS), .PRESC_W(PRESC_W)
    ) dut (
        .CLK(CLK), .rst(rst), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .busy(busy),
        .frame_done(frame_done), .pkt_done(pkt_done), .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        int         presc;
        bit         exp_par;
        int         exp_p;
    } vec_t;
    vec_t vecs[9];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input bit l);
        int g;
        g = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && g < 5000) begin step(); g++; end
        chk(in_ready == 1'b1, "push_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    // Waits for a start bit, then samples the whole frame cycle by cycle and
    // compares it against the line waveform built from the byte and config.
    task automatic check_frame(input logic [7:0] d, input bit exp_pk, input int p,
                               input bit pe, input bit ep, output int waited);
        int nb, len, bad_at, fd_n, pd_n;
        bit fd_last, pd_last;
        logic [11:0] exp_bits;
        waited = 0;
        while (TX_OUT !== 1'b0 && waited < 400) begin step(); waited++; end
        chk(TX_OUT === 1'b0, $sformatf("start_bit[%02h]", d), int'(TX_OUT), 0);
        if (TX_OUT !== 1'b0) return;
        nb = 1 + DATA_W + (pe ? 1 : 0) + STOP_BITS;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) exp_bits[1+i] = d[i];
        if (pe) exp_bits[1+DATA_W] = ep;
        len = nb * p;
        bad_at = -1; fd_n = 0; pd_n = 0; fd_last = 0; pd_last = 0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) step();
            if (TX_OUT !== exp_bits[k/p] && bad_at < 0) bad_at = k;
            if (frame_done === 1'b1) begin fd_n++; if (k == len-1) fd_last = 1; end
            if (pkt_done === 1'b1)   begin pd_n++; if (k == len-1) pd_last = 1; end
        end
        chk(bad_at < 0, $sformatf("frame_bits[%02h] first bad cycle", d), bad_at, -1);
        chk(fd_n == 1 && fd_last, $sformatf("frame_done[%02h] pulses", d), fd_n, 1);
        chk(pd_n == int'(exp_pk) && pd_last == exp_pk,
            $sformatf("pkt_done[%02h] pulses", d), pd_n, int'(exp_pk));
    endtask

    // Last data frame of a packet, plus the checksum frame when enabled.
    task automatic expect_last(input logic [7:0] d, input logic [7:0] acc, input int p,
                               input bit pe, input bit pt, input bit ep);
        int w;
`ifdef CMD_CHECKSUM_EN
        check_frame(d, 1'b0, p, pe, ep, w);
        check_frame(acc, 1'b1, p, pe, (^acc) ^ pt, w);
        chk(w == 1, "csum_contiguous wait", w, 1);
`else
        check_frame(d, 1'b1, p, pe, ep, w);
`endif
    endtask

    task automatic check_gap(input int p);
        int n;
        bit line_ok;
        n = 0; line_ok = 1;
        step();
        while (busy && n < 1000) begin
            if (TX_OUT !== 1'b1) line_ok = 0;
            step();
            n++;
        end
        chk(n == GAP_BITS * p, "gap_cycles", n, GAP_BITS * p);
        chk(line_ok, "gap_line_high", int'(line_ok), 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || fifo_count != 0) && g < 3000) begin step(); g++; end
        chk(!busy && fifo_count == 0, "idle_reached busy", int'(busy), 0);
    endtask

    task automatic t_back_to_back();
        int w;
        PAR_EN = 1; PAR_TYP = 0; PRESCALE = 4;
        fork
            begin
                push_byte(8'hAA, 0); push_byte(8'h05, 0); push_byte(8'h3C, 1);
            end
            begin
                check_frame(8'hAA, 0, 4, 1, 0, w);
                check_frame(8'h05, 0, 4, 1, 0, w);
                chk(w == 1, "b2b_contiguous_2", w, 1);
`ifdef CMD_CHECKSUM_EN
                check_frame(8'h3C, 0, 4, 1, 0, w);
                chk(w == 1, "b2b_contiguous_3", w, 1);
                check_frame(8'h93, 1, 4, 1, 0, w);
                chk(w == 1, "b2b_contiguous_csum", w, 1);
`else
                check_frame(8'h3C, 1, 4, 1, 0, w);
                chk(w == 1, "b2b_contiguous_3", w, 1);
`endif
                check_gap(4);
            end
        join
        wait_idle();
    endtask

    task automatic t_parity_toggle();
        int w;
        PAR_EN = 1; PAR_TYP = 0; PRESCALE = 6;
        fork
            begin
                push_byte(8'hBB, 0); push_byte(8'hBB, 1);
                repeat (10) step();
                PAR_TYP = 1;
            end
            begin
                check_frame(8'hBB, 0, 6, 1, 1'b0, w);
                expect_last(8'hBB, 8'h00, 6, 1, 1, 1'b1);
                check_gap(6);
            end
        join
        wait_idle();
    endtask

    task automatic t_fifo_full();
        int w;
        logic [7:0] acc;
        PAR_EN = 0; PAR_TYP = 0; PRESCALE = 16;
        fork
            begin
                for (int i = 0; i < 17; i++) push_byte(8'(i * 37 + 5), 0);
                chk(fifo_count == CW'(16), "full_count", int'(fifo_count), 16);
                chk(in_ready == 1'b0, "full_in_ready", int'(in_ready), 0);
                in_data = 8'(17 * 37 + 5); in_last = 1; in_valid = 1;
                repeat (20) step();
                chk(fifo_count == CW'(16), "held_off_count", int'(fifo_count), 16);
                chk(in_ready == 1'b0, "held_off_in_ready", int'(in_ready), 0);
                push_byte(8'(17 * 37 + 5), 1);
            end
            begin
                acc = '0;
                for (int i = 0; i < 17; i++) begin
                    acc ^= 8'(i * 37 + 5);
                    check_frame(8'(i * 37 + 5), 0, 16, 0, 0, w);
                end
                acc ^= 8'(17 * 37 + 5);
                expect_last(8'(17 * 37 + 5), acc, 16, 0, 0, 0);
            end
        join
        wait_idle();
    endtask

    task automatic t_reset_mid_frame();
        int bad;
        PAR_EN = 0; PAR_TYP = 0; PRESCALE = 8;
        push_byte(8'hDD, 0); push_byte(8'h11, 0); push_byte(8'h22, 1);
        repeat (34) step();
        chk(busy == 1'b1, "pre_rst_busy", int'(busy), 1);
        chk(TX_OUT == 1'b1, "pre_rst_data_bit3", int'(TX_OUT), 1);
        chk(fifo_count == CW'(2), "pre_rst_count", int'(fifo_count), 2);
        rst = 1;
        #1;
        chk(frame_done == 1'b0 && pkt_done == 1'b0, "rst_no_pulse", int'(frame_done), 0);
        chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
        step();
        chk(TX_OUT == 1'b1, "rst_tx_high", int'(TX_OUT), 1);
        chk(fifo_count == '0, "rst_flush", int'(fifo_count), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        rst = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (TX_OUT !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk(bad == 0, "post_rst_quiet bad cycles", bad, 0);
        fork
            push_byte(8'h5A, 1);
            begin expect_last(8'h5A, 8'h5A, 8, 0, 0, 0); check_gap(8); end
        join
        wait_idle();
    endtask

    task automatic t_random_round();
        int n, p;
        bit pe, pt;
        logic [8:0] q[$];
        pe = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        PAR_EN = pe; PAR_TYP = pt;
        PRESCALE = PRESC_W'($urandom_range(0, 10));
        p = (int'(PRESCALE) < 4) ? 4 : int'(PRESCALE);
        n = $urandom_range(5, 9);
        fork
            begin
                logic [7:0] d;
                bit l;
                for (int i = 0; i < n; i++) begin
                    d = 8'($urandom_range(0, 255));
                    l = (i == n - 1) || ($urandom_range(0, 2) == 0);
                    push_byte(d, l);
                    q.push_back({l, d});
                    repeat ($urandom_range(0, 3)) step();
                end
            end
            begin
                logic [8:0] e;
                logic [7:0] acc;
                int g, w;
                acc = '0;
                for (int i = 0; i < n; i++) begin
                    g = 0;
                    while (q.size() == 0 && g < 2000) begin step(); g++; end
                    if (q.size() == 0) begin
                        chk(0, "model_queue_empty", 0, 1);
                        break;
                    end
                    e = q.pop_front();
                    acc ^= e[7:0];
                    if (e[8]) begin
                        expect_last(e[7:0], acc, p, pe, pt, (^e[7:0]) ^ pt);
                        acc = '0;
                    end else begin
                        check_frame(e[7:0], 0, p, pe, (^e[7:0]) ^ pt, w);
                    end
                end
            end
        join
        wait_idle();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hAA, 1'b1, 1'b1,  8, 1'b1,  8};
        vecs[1] = '{8'hBB, 1'b1, 1'b0,  8, 1'b0,  8};
        vecs[2] = '{8'hCC, 1'b0, 1'b0,  2, 1'b0,  4};
        vecs[3] = '{8'hDD, 1'b1, 1'b1,  5, 1'b1,  5};
        vecs[4] = '{8'h00, 1'b1, 1'b0,  3, 1'b0,  4};
        vecs[5] = '{8'hFF, 1'b1, 1'b1,  4, 1'b1,  4};
        vecs[6] = '{8'h01, 1'b0, 1'b1,  6, 1'b0,  6};
        vecs[7] = '{8'h80, 1'b1, 1'b0,  0, 1'b1,  4};
        vecs[8] = '{8'h3C, 1'b1, 1'b1, 63, 1'b1, 63};

        rst = 1; in_data = '0; in_last = 0; in_valid = 0;
        PAR_EN = 0; PAR_TYP = 0; PRESCALE = 8;
        #1;
        chk(in_ready == 1'b0, "reset_in_ready", int'(in_ready), 0);
        repeat (3) step();
        chk(TX_OUT == 1'b1, "reset_tx", int'(TX_OUT), 1);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(fifo_count == '0, "reset_count", int'(fifo_count), 0);
        chk(frame_done == 1'b0 && pkt_done == 1'b0, "reset_pulses", int'(frame_done), 0);
        rst = 0;
        #1;
        chk(in_ready == 1'b1, "post_reset_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            PAR_EN = vecs[i].pe; PAR_TYP = vecs[i].pt;
            PRESCALE = PRESC_W'(vecs[i].presc);
            fork
                push_byte(vecs[i].data, 1);
                begin
                    expect_last(vecs[i].data, vecs[i].data, vecs[i].exp_p,
                                vecs[i].pe, vecs[i].pt, vecs[i].exp_par);
                    check_gap(vecs[i].exp_p);
                end
            join
            wait_idle();
        end

        t_back_to_back();
        t_parity_toggle();
        t_fifo_full();
        t_reset_mid_frame();
        for (int r = 0; r < 5; r++) t_random_round();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
